xgmii_rx_deframer: RTL and testbench
====================================

Name: xgmii_rx_deframer

Overview:
Downstream consumer of the 64-bit XGMII receive stream in the sys_156 domain. It decodes 8-lane XGMII words (lane 0 = bits [7:0]/rxc[0]) into a framed payload stream and strips start and preamble. It marks last-word byte enables, reports per-frame length and error status, and keeps wrapping frame and error statistics. Feeds the MAC receive FIFO.

Parameters:
MAX_LEN, 9600, payload bytes (incl. FCS) beyond which a frame is truncated and flagged
CNT_W, 32, width of statistics counters

Ports:
sys_156  input  1  156.25 MHz clock; all logic on rising edge
sys_rst_n  input  1  asynchronous active-low reset
xgmii_rxd  input  64  XGMII receive data, lane k = bits [8k+7:8k]
xgmii_rxc  input  8  XGMII receive control, bit k qualifies lane k
rx_data  output  64  payload word, byte 0 in [7:0]
rx_keep  output  8  byte enables for rx_data; contiguous from bit 0
rx_valid  output  1  rx_data/rx_keep/rx_sof/rx_eof valid this cycle
rx_sof  output  1  first payload word of frame
rx_eof  output  1  last payload word of frame
rx_err  output  1  frame errored; valid only with rx_eof
rx_len  output  16  payload byte count incl. FCS; valid only with rx_eof
frame_cnt  output  CNT_W  good frames delivered, wraps
err_cnt  output  CNT_W  errored/truncated frames, wraps
align_cnt  output  CNT_W  starts seen outside lane 0 or bad preamble, wraps

Behaviour:
- Reset: all outputs 0, counters 0, state IDLE, hold register empty. Reset mid-frame drops the frame with no eof.
- Start word: rxc=8'h01, lane0=FB, lanes1-6=55, lane7=D5. It produces no output and enters DATA with byte_cnt=0 and sof_pend=1.
- FB with ctrl in lane 4 in IDLE: align_cnt+1, go DROP. Lane-0 FB with any other preamble byte or rxc pattern: align_cnt+1, go DROP.
- Other words in IDLE (idles, garbage): ignored.
- Hold register: one payload word is buffered so that a terminate in lane 0 can mark the previous word eof. Output is registered. Fixed latency is 2 cycles from word input to rx_valid for non-final words.
- DATA, rxc=00: if hold is full, emit hold (keep=FF, sof=sof_pend, then clear sof_pend). Load the input into hold. byte_cnt+=8.
- DATA, terminate FD with ctrl in lane k, lanes <k all rxc=0:
  - k=0: emit hold with eof, keep=FF, len=byte_cnt. Go IDLE.
  - k>0: emit hold (not eof). Load the partial into hold with keep=(1<<k)-1, byte_cnt+=k. Go FLUSH.
- FLUSH: emit hold with eof and len (one cycle), then go IDLE. An input start word arriving in FLUSH is decoded normally (it produces no output, so there is no conflict).
- Frame shorter than one full word (terminate in the first data word) is legal. A single word is emitted with sof=eof=1.
- Frame with no payload (terminate in lane 0 immediately after the start word) produces no output. err_cnt+1.
- DATA, any other control lane (FE, 07, misplaced FD): emit hold with eof=1, err=1. err_cnt+1. Go DROP.
- byte_cnt would exceed MAX_LEN: same as the error case (truncate, eof+err), go DROP.
- DROP: discard until a word containing FD with ctrl or an all-idle word (rxc=FF, all 07), then go IDLE.
- rx_len saturates at 16'hFFFF.
- frame_cnt increments on eof without err. err_cnt increments on eof with err. Counters wrap.
- rx_err and rx_len are 0 whenever rx_eof=0.

Test Plan:
- 64-byte frame: start word, 8 data words 0x00..0x3F, idle word with FD in lane 0 -> 8 rx_valid beats, first sof, last eof keep=FF len=64; frame_cnt=1.
- 60-byte frame: 7 full words + terminate in lane 4 -> 8 beats, last keep=0x0F, eof, len=60, err=0.
- 3-byte frame: terminate in lane 3 of first data word -> single beat sof=eof=1, keep=0x07, len=3.
- FE ctrl in lane 2 of word 4 -> word 3 emitted eof=1 err=1; no output until idle; err_cnt=1, frame_cnt unchanged.
- FB in lane 4, then a valid frame -> first frame discarded, align_cnt=1; second frame delivered intact.
- sys_rst_n low for 1 cycle mid-frame -> all outputs 0 asynchronously; next back-to-back frame (start immediately after FLUSH) delivered correctly; 9608-byte frame truncated at MAX_LEN with err.

Source files
------------

// File: rtl/xgmii_rx_deframer.sv
// XGMII 64-bit receive deframer: strips start/preamble, emits a framed payload
// stream with byte enables, per-frame length/error, and wrapping statistics.
module xgmii_rx_deframer #(
    parameter int MAX_LEN = 9600,
    parameter int CNT_W   = 32
) (
    input  logic             sys_156,
    input  logic             sys_rst_n,
    input  logic [63:0]      xgmii_rxd,
    input  logic [7:0]       xgmii_rxc,
    output logic [63:0]      rx_data,
    output logic [7:0]       rx_keep,
    output logic             rx_valid,
    output logic             rx_sof,
    output logic             rx_eof,
    output logic             rx_err,
    output logic [15:0]      rx_len,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] align_cnt
);

    localparam logic [63:0] START_WORD = 64'hD555_5555_5555_55FB;
    localparam logic [63:0] IDLE_WORD  = {8{8'h07}};

    typedef enum logic [1:0] {IDLE, DATA, FLUSH, DROP} state_t;

    state_t      state;
    logic [63:0] hold_data;
    logic [7:0]  hold_keep;
    logic        hold_full;
    logic        sof_pend;
    logic [31:0] byte_cnt;

    logic [2:0]  ctrl_lane;
    logic        ctrl_any;
    logic        fd_any;
    logic [7:0]  term_keep;
    logic        ctrl_fd;
    logic        is_start;
    logic        bad_start;
    logic        idle_word;
    logic [31:0] full_cnt;
    logic [31:0] part_cnt;
    logic        full_over;
    logic        part_over;

    function automatic logic [15:0] sat_len(input logic [31:0] v);
        sat_len = (v > 32'h0000_FFFF) ? 16'hFFFF : v[15:0];
    endfunction

    // Lowest control lane decides the word: FD there is a terminate, anything else an error.
    always_comb begin
        ctrl_lane = 3'd0;
        ctrl_any  = 1'b0;
        fd_any    = 1'b0;
        term_keep = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            if (xgmii_rxc[i]) begin
                ctrl_lane = 3'(i);
                ctrl_any  = 1'b1;
            end
        end
        for (int i = 0; i < 8; i++) begin
            if (xgmii_rxc[i] && (xgmii_rxd[8*i +: 8] == 8'hFD))
                fd_any = 1'b1;
            term_keep[i] = (3'(i) < ctrl_lane);
        end
    end

    assign ctrl_fd   = ctrl_any && (xgmii_rxd[{ctrl_lane, 3'b000} +: 8] == 8'hFD);
    assign is_start  = (xgmii_rxc == 8'h01) && (xgmii_rxd == START_WORD);
    assign bad_start = !is_start &&
                       ((xgmii_rxc[0] && (xgmii_rxd[7:0] == 8'hFB)) ||
                        (xgmii_rxc[4] && (xgmii_rxd[39:32] == 8'hFB)));
    assign idle_word = (xgmii_rxc == 8'hFF) && (xgmii_rxd == IDLE_WORD);
    assign full_cnt  = byte_cnt + 32'd8;
    assign part_cnt  = byte_cnt + {29'd0, ctrl_lane};
    assign full_over = full_cnt > 32'(MAX_LEN);
    assign part_over = part_cnt > 32'(MAX_LEN);

    always_ff @(posedge sys_156 or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= IDLE;
            hold_data <= '0;
            hold_keep <= '0;
            hold_full <= 1'b0;
            sof_pend  <= 1'b0;
            byte_cnt  <= '0;
            rx_data   <= '0;
            rx_keep   <= '0;
            rx_valid  <= 1'b0;
            rx_sof    <= 1'b0;
            rx_eof    <= 1'b0;
            rx_err    <= 1'b0;
            rx_len    <= '0;
            frame_cnt <= '0;
            err_cnt   <= '0;
            align_cnt <= '0;
        end else begin
            rx_valid <= 1'b0;
            rx_data  <= '0;
            rx_keep  <= '0;
            rx_sof   <= 1'b0;
            rx_eof   <= 1'b0;
            rx_err   <= 1'b0;
            rx_len   <= '0;
            case (state)
                IDLE, FLUSH: begin
                    if (state == FLUSH) begin
                        rx_valid  <= 1'b1;
                        rx_data   <= hold_data;
                        rx_keep   <= hold_keep;
                        rx_sof    <= sof_pend;
                        rx_eof    <= 1'b1;
                        rx_len    <= sat_len(byte_cnt);
                        frame_cnt <= frame_cnt + CNT_W'(1);
                        hold_full <= 1'b0;
                        sof_pend  <= 1'b0;
                    end
                    // A start word right behind a terminate is taken in the FLUSH cycle.
                    if (is_start) begin
                        state     <= DATA;
                        byte_cnt  <= '0;
                        sof_pend  <= 1'b1;
                        hold_full <= 1'b0;
                    end else if (bad_start) begin
                        align_cnt <= align_cnt + CNT_W'(1);
                        state     <= DROP;
                    end else begin
                        state <= IDLE;
                    end
                end
                DATA: begin
                    if (!ctrl_any && !full_over) begin
                        if (hold_full) begin
                            rx_valid <= 1'b1;
                            rx_data  <= hold_data;
                            rx_keep  <= hold_keep;
                            rx_sof   <= sof_pend;
                            sof_pend <= 1'b0;
                        end
                        hold_data <= xgmii_rxd;
                        hold_keep <= 8'hFF;
                        hold_full <= 1'b1;
                        byte_cnt  <= full_cnt;
                    end else if (ctrl_fd && (ctrl_lane == 3'd0)) begin
                        if (hold_full) begin
                            rx_valid  <= 1'b1;
                            rx_data   <= hold_data;
                            rx_keep   <= hold_keep;
                            rx_sof    <= sof_pend;
                            rx_eof    <= 1'b1;
                            rx_len    <= sat_len(byte_cnt);
                            frame_cnt <= frame_cnt + CNT_W'(1);
                        end else begin
                            err_cnt <= err_cnt + CNT_W'(1);
                        end
                        hold_full <= 1'b0;
                        sof_pend  <= 1'b0;
                        state     <= IDLE;
                    end else if (ctrl_fd && !part_over) begin
                        if (hold_full) begin
                            rx_valid <= 1'b1;
                            rx_data  <= hold_data;
                            rx_keep  <= hold_keep;
                            rx_sof   <= sof_pend;
                            sof_pend <= 1'b0;
                        end
                        hold_data <= xgmii_rxd;
                        hold_keep <= term_keep;
                        hold_full <= 1'b1;
                        byte_cnt  <= part_cnt;
                        state     <= FLUSH;
                    end else begin
                        // Bad control or overlength: close what is held as errored.
                        if (hold_full) begin
                            rx_valid <= 1'b1;
                            rx_data  <= hold_data;
                            rx_keep  <= hold_keep;
                            rx_sof   <= sof_pend;
                            rx_eof   <= 1'b1;
                            rx_err   <= 1'b1;
                            rx_len   <= sat_len(byte_cnt);
                        end
                        err_cnt   <= err_cnt + CNT_W'(1);
                        hold_full <= 1'b0;
                        sof_pend  <= 1'b0;
                        state     <= DROP;
                    end
                end
                DROP: begin
                    if (fd_any || idle_word)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_xgmii_rx_deframer.sv
// Directed + randomized bench for xgmii_rx_deframer; expected beats come from a
// byte-queue model of each frame (chunk payload into 8-byte words).
module tb_xgmii_rx_deframer;

    localparam int MAX_LEN = 9600;
    localparam int CNT_W   = 32;
    localparam logic [63:0] START_D = 64'hD555_5555_5555_55FB;
    localparam logic [63:0] IDLE_D  = {8{8'h07}};

    logic             sys_156 = 1'b0;
    logic             sys_rst_n;
    logic [63:0]      xgmii_rxd;
    logic [7:0]       xgmii_rxc;
    logic [63:0]      rx_data;
    logic [7:0]       rx_keep;
    logic             rx_valid, rx_sof, rx_eof, rx_err;
    logic [15:0]      rx_len;
    logic [CNT_W-1:0] frame_cnt, err_cnt, align_cnt;

    xgmii_rx_deframer #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
        .sys_156(sys_156), .sys_rst_n(sys_rst_n),
        .xgmii_rxd(xgmii_rxd), .xgmii_rxc(xgmii_rxc),
        .rx_data(rx_data), .rx_keep(rx_keep), .rx_valid(rx_valid),
        .rx_sof(rx_sof), .rx_eof(rx_eof), .rx_err(rx_err), .rx_len(rx_len),
        .frame_cnt(frame_cnt), .err_cnt(err_cnt), .align_cnt(align_cnt)
    );

    always #5 sys_156 = ~sys_156;

    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        sof;
        logic        eof;
        logic        err;
        logic [15:0] len;
    } beat_t;

    beat_t      got[$];
    beat_t      exp_q[$];
    logic [7:0] pl[$];
    int checks = 0;
    int errors = 0;
    int exp_frm = 0;
    int exp_err = 0;
    int exp_aln = 0;

    always @(negedge sys_156) begin
        beat_t b;
        if (rx_valid === 1'b1) begin
            b.data = rx_data; b.keep = rx_keep; b.sof = rx_sof;
            b.eof = rx_eof;   b.err = rx_err;   b.len = rx_len;
            got.push_back(b);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic word(input logic [63:0] d, input logic [7:0] c);
        xgmii_rxd = d;
        xgmii_rxc = c;
        @(posedge sys_156);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) word(IDLE_D, 8'hFF);
    endtask

    function automatic logic [63:0] pl_word(input int base, input int cnt);
        logic [63:0] d;
        d = '0;
        for (int i = 0; i < cnt; i++) d[8*i +: 8] = pl[base+i];
        return d;
    endfunction

    task automatic fill_pl(input int n, input bit ramp);
        pl.delete();
        for (int i = 0; i < n; i++) pl.push_back(ramp ? 8'(i) : 8'($urandom));
    endtask

    // Reference: the first d payload bytes delivered in 8-byte beats.
    task automatic expect_beats(input int d, input bit err);
        for (int w = 0; w * 8 < d; w++) begin
            beat_t b;
            int cnt;
            cnt    = (d - 8*w >= 8) ? 8 : d - 8*w;
            b.data = pl_word(8*w, cnt);
            b.keep = 8'((16'd1 << cnt) - 16'd1);
            b.sof  = (w == 0);
            b.eof  = (8*w + cnt == d);
            b.err  = b.eof && err;
            b.len  = b.eof ? 16'(d) : 16'd0;
            exp_q.push_back(b);
        end
        if (err) exp_err++; else exp_frm++;
    endtask

    task automatic send_frame();
        int n, full, k;
        logic [63:0] d;
        logic [7:0]  c;
        n = pl.size(); full = n / 8; k = n % 8;
        word(START_D, 8'h01);
        for (int w = 0; w < full; w++) word(pl_word(8*w, 8), 8'h00);
        d = pl_word(8*full, k);
        c = 8'h00;
        for (int b = k; b < 8; b++) begin
            d[8*b +: 8] = (b == k) ? 8'hFD : 8'h07;
            c[b] = 1'b1;
        end
        word(d, c);
        if (n == 0) expect_beats(0, 1'b1);
        else if (n > MAX_LEN) expect_beats(MAX_LEN, 1'b1);
        else expect_beats(n, 1'b0);
    endtask

    // w good words, then FE at lane j, trailing junk, then an idle word.
    task automatic send_err_frame(input int w, input int j);
        logic [63:0] d;
        logic [7:0]  c;
        fill_pl(8*w + j, 1'b0);
        word(START_D, 8'h01);
        for (int i = 0; i < w; i++) word(pl_word(8*i, 8), 8'h00);
        d = pl_word(8*w, j);
        c = 8'h00;
        for (int b = j; b < 8; b++) begin
            d[8*b +: 8] = (b == j) ? 8'hFE : 8'h07;
            c[b] = 1'b1;
        end
        word(d, c);
        word({$urandom, $urandom}, 8'h00);
        word({$urandom, $urandom}, 8'h00);
        idle(1);
        expect_beats(8*w, 1'b1);
    endtask

    task automatic send_misaligned(input bit lane4);
        if (lane4) word({8'h55, 8'h55, 8'h55, 8'hFB, 8'h07, 8'h07, 8'h07, 8'h07}, 8'h1F);
        else       word(64'hD555_5555_5455_55FB, 8'h01);
        repeat (3) word({$urandom, $urandom}, 8'h00);
        word({{7{8'h07}}, 8'hFD}, 8'hFF);
        exp_aln++;
    endtask

    task automatic flush_and_compare(input string tag);
        logic [63:0] mask;
        idle(4);
        check({tag, " beats"}, 64'(got.size()), 64'(exp_q.size()));
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            for (int b = 0; b < 8; b++) mask[8*b +: 8] = {8{exp_q[i].keep[b]}};
            check($sformatf("%s b%0d data", tag, i), got[i].data & mask, exp_q[i].data);
            check($sformatf("%s b%0d keep", tag, i), 64'(got[i].keep), 64'(exp_q[i].keep));
            check($sformatf("%s b%0d sof", tag, i),  64'(got[i].sof),  64'(exp_q[i].sof));
            check($sformatf("%s b%0d eof", tag, i),  64'(got[i].eof),  64'(exp_q[i].eof));
            check($sformatf("%s b%0d err", tag, i),  64'(got[i].err),  64'(exp_q[i].err));
            check($sformatf("%s b%0d len", tag, i),  64'(got[i].len),  64'(exp_q[i].len));
        end
        check({tag, " frame_cnt"}, 64'(frame_cnt), 64'(exp_frm));
        check({tag, " err_cnt"},   64'(err_cnt),   64'(exp_err));
        check({tag, " align_cnt"}, 64'(align_cnt), 64'(exp_aln));
        got.delete();
        exp_q.delete();
    endtask

    task automatic check_zero(input string tag);
        check({tag, " rx_valid"},  64'(rx_valid),  64'd0);
        check({tag, " rx_data"},   rx_data,        64'd0);
        check({tag, " rx_keep"},   64'(rx_keep),   64'd0);
        check({tag, " rx_sof"},    64'(rx_sof),    64'd0);
        check({tag, " rx_eof"},    64'(rx_eof),    64'd0);
        check({tag, " rx_err"},    64'(rx_err),    64'd0);
        check({tag, " rx_len"},    64'(rx_len),    64'd0);
        check({tag, " frame_cnt"}, 64'(frame_cnt), 64'd0);
        check({tag, " err_cnt"},   64'(err_cnt),   64'd0);
        check({tag, " align_cnt"}, 64'(align_cnt), 64'd0);
    endtask

    initial begin
        sys_rst_n = 1'b0;
        xgmii_rxd = IDLE_D;
        xgmii_rxc = 8'hFF;
        repeat (3) @(posedge sys_156);
        #1;
        check_zero("reset");
        sys_rst_n = 1'b1;
        idle(2);

        fill_pl(64, 1'b1); send_frame(); flush_and_compare("f64");
        fill_pl(60, 1'b0); send_frame(); flush_and_compare("f60");
        fill_pl(3, 1'b0);  send_frame(); flush_and_compare("f3");
        send_err_frame(3, 2); flush_and_compare("fe");

        send_misaligned(1'b1);
        fill_pl(40, 1'b0); send_frame(); flush_and_compare("lane4");
        send_misaligned(1'b0);
        fill_pl(9, 1'b0);  send_frame(); flush_and_compare("preamble");

        fill_pl(0, 1'b0);  send_frame(); flush_and_compare("empty");

        for (int r = 0; r < 8; r++) begin
            fill_pl($urandom_range(1, 100), 1'b0);
            send_frame();
            flush_and_compare($sformatf("rnd%0d", r));
        end
        for (int r = 0; r < 3; r++) begin
            send_err_frame($urandom_range(1, 4), $urandom_range(0, 7));
            flush_and_compare($sformatf("rnderr%0d", r));
        end

        // Reset mid-frame: everything in flight is lost, nothing further appears.
        fill_pl(48, 1'b0);
        word(START_D, 8'h01);
        for (int w = 0; w < 3; w++) word(pl_word(8*w, 8), 8'h00);
        #3;
        sys_rst_n = 1'b0;
        xgmii_rxd = IDLE_D;
        xgmii_rxc = 8'hFF;
        got.delete();
        exp_q.delete();
        exp_frm = 0; exp_err = 0; exp_aln = 0;
        #1;
        check_zero("midrst");
        @(posedge sys_156);
        #1;
        sys_rst_n = 1'b1;
        word(pl_word(24, 8), 8'h00);
        idle(2);
        flush_and_compare("postrst");

        // Back-to-back: start word right after a partial terminate and after a lane-0 terminate.
        fill_pl(21, 1'b0); send_frame();
        fill_pl(17, 1'b0); send_frame();
        fill_pl(16, 1'b0); send_frame();
        fill_pl(13, 1'b0); send_frame();
        flush_and_compare("b2b");

        fill_pl(MAX_LEN, 1'b0);     send_frame(); flush_and_compare("maxlen");
        fill_pl(MAX_LEN + 8, 1'b0); send_frame(); flush_and_compare("trunc");
        fill_pl(10, 1'b0);          send_frame(); flush_and_compare("aftertrunc");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
